// File: rtl/count_sequencer.sv
// count_sequencer: run/pause/step controller for the display event counter.
// It holds the count register, a clock prescaler, terminal-count detection
// and an IDLE/RUN/PAUSE/DONE state machine.
//
// Ports
//   Clock        clock, rising edge
//   Resetn       synchronous active-low reset
//   start        begin counting (IDLE/DONE) or resume it (PAUSE)
//   stop         pause counting while in RUN
//   step         one advance per cycle while in PAUSE
//   clear        return to IDLE with count = 0
//   dir          1 = count up, 0 = count down
//   auto_reload  1 = reload at the terminal value, 0 = stop in DONE
//   limit        terminal value when counting up, start value when counting down
//   count        current count
//   tick         one-cycle pulse, count changed
//   wrap         one-cycle pulse, terminal value reached
//   busy         state == RUN
//   done         state == DONE
//   state        IDLE=00 RUN=01 PAUSE=10 DONE=11
module count_sequencer #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned PS_W     = 26
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             dir,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             wrap,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [PS_W-1:0]  ps;
    logic [PS_W-1:0]  nxt_ps;
    logic [WIDTH-1:0] nxt_count;
    logic             nxt_tick;
    logic             nxt_wrap;
    logic             adv;
    logic             term;
    logic [WIDTH-1:0] reload_val;

    // Terminal detection and reload value follow dir/limit live.
    assign term       = dir ? (count == limit) : (count == '0);
    assign reload_val = dir ? '0 : limit;
    assign state      = cur_state;

    // Next-state and output decode; priority clear > stop > start > step.
    always_comb begin
        nxt_state = cur_state;
        nxt_ps    = ps;
        nxt_count = count;
        nxt_tick  = 1'b0;
        nxt_wrap  = 1'b0;
        adv       = 1'b0;

        if (clear) begin
            nxt_state = IDLE;
            nxt_ps    = '0;
            nxt_count = '0;
        end else if (stop) begin
            if (cur_state == RUN) begin
                nxt_state = PAUSE;
            end
        end else if (start && (cur_state != RUN)) begin
            nxt_state = RUN;
            if (cur_state != PAUSE) begin
                nxt_count = reload_val;
                nxt_ps    = '0;
            end
        end else begin
            case (cur_state)
                RUN: begin
                    if (ps == PS_MAX) begin
                        nxt_ps = '0;
                        adv    = 1'b1;
                    end else begin
                        nxt_ps = ps + PS_W'(1);
                    end
                end
                PAUSE: begin
                    adv = step;
                end
                default: begin
                end
            endcase
        end

        if (adv) begin
            if (!term) begin
                nxt_count = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));
                nxt_tick  = 1'b1;
            end else if (auto_reload) begin
                nxt_count = reload_val;
                nxt_tick  = 1'b1;
                nxt_wrap  = 1'b1;
            end else begin
                nxt_wrap  = 1'b1;
                nxt_state = DONE;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cur_state <= IDLE;
            ps        <= '0;
            count     <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            ps        <= nxt_ps;
            count     <= nxt_count;
            tick      <= nxt_tick;
            wrap      <= nxt_wrap;
            busy      <= (nxt_state == RUN);
            done      <= (nxt_state == DONE);
        end
    end

endmodule
